// File: rtl/lfsr_stream.sv
// Multi-bit XNOR Fibonacci LFSR with a valid/ready output stream, reseeding and lockup guard.
// Optional accepted-word counter enabled by defining LFSR_STREAM_WORD_COUNT_EN.
module lfsr_stream #(
  parameter int               WIDTH        = 32,
  parameter int               OUT_BITS     = 8,
  parameter logic [WIDTH-1:0] POLYNOMIAL   = '0,
  parameter logic [WIDTH-1:0] SEED_DEFAULT = WIDTH'(1),
  parameter int               COUNT_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   seed_load,
  input  logic [WIDTH-1:0]       seed,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_BITS-1:0]    out_data,
  output logic                   lockup_fixed,
  output logic [COUNT_WIDTH-1:0] word_count
);

  function automatic logic [63:0] koopman(input int w);
    case (w)
      4:  return 64'h9;                 5:  return 64'h12;
      6:  return 64'h21;                7:  return 64'h41;
      8:  return 64'h8E;                9:  return 64'h108;
      10: return 64'h204;               11: return 64'h402;
      12: return 64'h829;               13: return 64'h100D;
      14: return 64'h2015;              15: return 64'h4001;
      16: return 64'h8016;              17: return 64'h10004;
      18: return 64'h20013;             19: return 64'h40013;
      20: return 64'h80004;             21: return 64'h100002;
      22: return 64'h200001;            23: return 64'h400010;
      24: return 64'h80000D;            25: return 64'h1000004;
      26: return 64'h2000023;           27: return 64'h4000013;
      28: return 64'h8000004;           29: return 64'h10000002;
      30: return 64'h20000029;          31: return 64'h40000004;
      32: return 64'h80000057;          33: return 64'h100000029;
      34: return 64'h200000073;         35: return 64'h400000002;
      36: return 64'h80000003B;         37: return 64'h100000001F;
      38: return 64'h2000000031;        39: return 64'h4000000008;
      40: return 64'h800000001C;        41: return 64'h10000000004;
      42: return 64'h2000000001F;       43: return 64'h4000000002C;
      44: return 64'h80000000032;       45: return 64'h10000000000D;
      46: return 64'h200000000097;      47: return 64'h400000000010;
      48: return 64'h80000000005B;      49: return 64'h1000000000038;
      50: return 64'h200000000000E;     51: return 64'h4000000000025;
      52: return 64'h8000000000004;     53: return 64'h10000000000023;
      54: return 64'h2000000000003E;    55: return 64'h40000000000023;
      56: return 64'h8000000000004A;    57: return 64'h100000000000016;
      58: return 64'h200000000000031;   59: return 64'h40000000000003D;
      60: return 64'h800000000000001;   61: return 64'h1000000000000013;
      62: return 64'h2000000000000034;  63: return 64'h4000000000000001;
      64: return 64'h800000000000000D;
      default: return 64'h0;
    endcase
  endfunction

  localparam logic [WIDTH-1:0] POLY = (POLYNOMIAL != '0) ? POLYNOMIAL : WIDTH'(koopman(WIDTH));

  if (OUT_BITS < 1 || OUT_BITS > WIDTH) begin : g_bad_out_bits
    $error("lfsr_stream: OUT_BITS must be in 1..WIDTH");
  end
  if (WIDTH < 2) begin : g_bad_width
    $error("lfsr_stream: WIDTH must be at least 2");
  end
  if (POLYNOMIAL == '0 && (WIDTH < 4 || WIDTH > 64)) begin : g_no_table_poly
    $error("lfsr_stream: built-in polynomial table covers WIDTH 4..64 only");
  end
  if (SEED_DEFAULT == '1) begin : g_bad_seed
    $error("lfsr_stream: SEED_DEFAULT must not be the all-ones lockup state");
  end

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] t;
    t = s;
    for (int i = 0; i < OUT_BITS; i++) begin
      t = {t[WIDTH-2:0], ~^(t & POLY)};
    end
    return t;
  endfunction

  logic [WIDTH-1:0]    state_q, state_d, adv;
  logic [OUT_BITS-1:0] data_q, data_d;
  logic                valid_q, valid_d;
  logic                lock_q, lock_d;

  // Seed load overrides everything; otherwise refill when empty or when the word is taken.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    valid_d = valid_q;
    lock_d  = 1'b0;
    adv     = advance(state_q);
    if (seed_load) begin
      valid_d = 1'b0;
      if (&seed) begin
        state_d = '0;
        lock_d  = 1'b1;
      end else begin
        state_d = seed;
      end
    end else if (!valid_q || out_ready) begin
      state_d = adv;
      data_d  = adv[OUT_BITS-1:0];
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SEED_DEFAULT;
      data_q  <= '0;
      valid_q <= 1'b0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      lock_q  <= lock_d;
    end
  end

  assign out_valid    = valid_q;
  assign out_data     = data_q;
  assign lockup_fixed = lock_q;

`ifdef LFSR_STREAM_WORD_COUNT_EN
  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] c);
    return (&c) ? c : c + COUNT_WIDTH'(1);
  endfunction

  logic [COUNT_WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (seed_load) begin
      count_d = '0;
    end else if (valid_q && out_ready) begin
      count_d = sat_inc(count_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign word_count = count_q;
`else
  assign word_count = '0;
`endif

endmodule

// File: tb/tb_lfsr_stream.sv
// Bench for lfsr_stream: three instances (4b/1b, 4b/4b, 32b/8b) checked against a word-level reference model.
module tb_lfsr_stream;
  localparam int N = 3;
`ifdef LFSR_STREAM_WORD_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic        sl [N];
  logic [63:0] sd [N];
  logic        rd [N];

  logic v0, v1, v2, l0, l1, l2;
  logic d0;
  logic [3:0] d1;
  logic [7:0] d2;
  logic [31:0] c0, c1, c2;

  logic        ov [N];
  logic        ol [N];
  logic [63:0] od [N];
  logic [31:0] oc [N];

  always_comb begin
    ov[0] = v0; ov[1] = v1; ov[2] = v2;
    ol[0] = l0; ol[1] = l1; ol[2] = l2;
    od[0] = {63'd0, d0}; od[1] = {60'd0, d1}; od[2] = {56'd0, d2};
    oc[0] = c0; oc[1] = c1; oc[2] = c2;
  end

  lfsr_stream #(.WIDTH(4), .OUT_BITS(1)) dut0 (
    .clk(clk), .reset(reset), .seed_load(sl[0]), .seed(sd[0][3:0]), .out_valid(v0),
    .out_ready(rd[0]), .out_data(d0), .lockup_fixed(l0), .word_count(c0));
  lfsr_stream #(.WIDTH(4), .OUT_BITS(4)) dut1 (
    .clk(clk), .reset(reset), .seed_load(sl[1]), .seed(sd[1][3:0]), .out_valid(v1),
    .out_ready(rd[1]), .out_data(d1), .lockup_fixed(l1), .word_count(c1));
  lfsr_stream dut2 (
    .clk(clk), .reset(reset), .seed_load(sl[2]), .seed(sd[2][31:0]), .out_valid(v2),
    .out_ready(rd[2]), .out_data(d2), .lockup_fixed(l2), .word_count(c2));

  // Reference model: per-instance word stream state
  logic [63:0] m_state [N];
  logic [63:0] m_data  [N];
  logic        m_valid [N];
  logic        m_lock  [N];
  logic [31:0] m_cnt   [N];
  logic [63:0] first_w2;

  // State sequence of the 4-bit, taps 4'h9 generator starting from 0
  logic [3:0] st15 [15] = '{4'h1, 4'h2, 4'h5, 4'hA, 4'h4, 4'h9, 4'h3, 4'h6,
                            4'hD, 4'hB, 4'h7, 4'hE, 4'hC, 4'h8, 4'h0};

  function automatic int wid(input int i);
    return (i == 2) ? 32 : 4;
  endfunction
  function automatic int obits(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 4 : 8);
  endfunction
  function automatic logic [63:0] poly(input int i);
    return (i == 2) ? 64'h80000057 : 64'h9;
  endfunction
  function automatic logic [63:0] wmask(input int w);
    return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction
  function automatic logic [63:0] step1(input logic [63:0] s, input int i);
    return ((s << 1) | {63'd0, ~^(s & poly(i))}) & wmask(wid(i));
  endfunction
  function automatic logic [31:0] exp_cnt(input int i);
    return CNT_EN ? m_cnt[i] : 32'd0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_state[i] = 64'd1;
      m_data[i]  = 64'd0;
      m_valid[i] = 1'b0;
      m_lock[i]  = 1'b0;
      m_cnt[i]   = 32'd0;
    end
  endtask

  // One clock edge: apply the stream rules to the model, then settle
  task automatic tick();
    logic [63:0] mask, s;
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      mask = wmask(wid(i));
      if (sl[i]) begin
        s = sd[i] & mask;
        m_lock[i]  = (s == mask);
        m_state[i] = m_lock[i] ? 64'd0 : s;
        m_valid[i] = 1'b0;
        m_cnt[i]   = 32'd0;
      end else begin
        m_lock[i] = 1'b0;
        if (m_valid[i] && rd[i] && m_cnt[i] != 32'hFFFF_FFFF) m_cnt[i] = m_cnt[i] + 32'd1;
        if (!m_valid[i] || rd[i]) begin
          for (int k = 0; k < obits(i); k++) m_state[i] = step1(m_state[i], i);
          m_data[i]  = m_state[i] & wmask(obits(i));
          m_valid[i] = 1'b1;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < N; i++) begin sl[i] = 1'b0; sd[i] = 64'd0; rd[i] = 1'b0; end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      checks++;
      if (ov[i] !== 1'b0 || od[i] !== 64'd0 || ol[i] !== 1'b0 || oc[i] !== 32'd0) begin
        failures++;
        $display("FAIL reset_state dut%0d valid=%b data=%h lock=%b cnt=%0d want all zero", i, ov[i], od[i], ol[i], oc[i]);
      end
    end
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    tick();
    for (int i = 0; i < N; i++) begin
      checks++;
      if (ov[i] !== 1'b1 || od[i] !== m_data[i]) begin
        failures++;
        $display("FAIL first_fill dut%0d valid=%b data=%h want valid=1 data=%h", i, ov[i], od[i], m_data[i]);
      end
    end
    first_w2 = m_data[2];
  endtask

  task automatic test_period_w4();
    for (int i = 0; i < 2; i++) begin sl[i] = 1'b1; sd[i] = 64'd0; rd[i] = 1'b1; end
    tick();
    sl[0] = 1'b0; sl[1] = 1'b0;
    checks++;
    if (ov[0] !== 1'b0 || ov[1] !== 1'b0) begin
      failures++;
      $display("FAIL seed_clears_valid got %b%b want 00", ov[0], ov[1]);
    end
    tick();
    checks++;
    if (ov[1] !== 1'b1 || od[1] !== 64'hA) begin
      failures++;
      $display("FAIL w4_ob4_first got valid=%b data=%h want 1/a", ov[1], od[1]);
    end
    for (int k = 0; k < 30; k++) begin
      checks++;
      if (ov[0] !== 1'b1 || od[0] !== {63'd0, st15[k % 15][0]}) begin
        failures++;
        $display("FAIL w4_ob1_seq word%0d got valid=%b data=%h want %h", k, ov[0], od[0], st15[k % 15][0]);
      end
      checks++;
      if (ov[1] !== 1'b1 || od[1] !== {60'd0, st15[(4 * (k + 1) - 1) % 15]}) begin
        failures++;
        $display("FAIL w4_ob4_seq word%0d got %h want %h", k, od[1], st15[(4 * (k + 1) - 1) % 15]);
      end
      tick();
    end
  endtask

  task automatic test_lockup();
    for (int i = 0; i < 2; i++) begin sl[i] = 1'b1; sd[i] = 64'hF; rd[i] = 1'b1; end
    tick();
    sl[0] = 1'b0; sl[1] = 1'b0;
    checks++;
    if (ol[0] !== 1'b1 || ol[1] !== 1'b1 || ov[0] !== 1'b0 || ov[1] !== 1'b0) begin
      failures++;
      $display("FAIL lockup_pulse lock=%b%b valid=%b%b want lock=11 valid=00", ol[0], ol[1], ov[0], ov[1]);
    end
    tick();
    checks++;
    if (ol[0] !== 1'b0 || ol[1] !== 1'b0 || od[0] !== 64'h1 || od[1] !== 64'hA || ov[0] !== 1'b1) begin
      failures++;
      $display("FAIL lockup_after lock=%b%b d0=%h d1=%h want lock=00 d0=1 d1=a", ol[0], ol[1], od[0], od[1]);
    end
  endtask

  task automatic test_stall();
    logic [63:0] held;
    sl[2] = 1'b1; sd[2] = {32'd0, $urandom} & 64'h7FFF_FFFF; rd[2] = 1'b0;
    tick();
    sl[2] = 1'b0;
    tick();
    checks++;
    if (ov[2] !== 1'b1 || od[2] !== m_data[2]) begin
      failures++;
      $display("FAIL stall_first got valid=%b data=%h want 1/%h", ov[2], od[2], m_data[2]);
    end
    held = m_data[2];
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if (ov[2] !== 1'b1 || od[2] !== held) begin
        failures++;
        $display("FAIL stall_hold cyc%0d got valid=%b data=%h want 1/%h", k, ov[2], od[2], held);
      end
    end
    rd[2] = 1'b1;
    tick();
    checks++;
    if (ov[2] !== 1'b1 || od[2] !== m_data[2]) begin
      failures++;
      $display("FAIL stall_release got %h want %h", od[2], m_data[2]);
    end
  endtask

  task automatic test_seed_during_transfer();
    rd[2] = 1'b1; sl[2] = 1'b1; sd[2] = {32'd0, $urandom} & 64'h7FFF_FFFF;
    tick();
    sl[2] = 1'b0;
    checks++;
    if (ov[2] !== 1'b0 || oc[2] !== 32'd0) begin
      failures++;
      $display("FAIL seed_xfer_clear got valid=%b cnt=%0d want 0/0", ov[2], oc[2]);
    end
    tick();
    checks++;
    if (ov[2] !== 1'b1 || od[2] !== m_data[2]) begin
      failures++;
      $display("FAIL seed_xfer_refill got valid=%b data=%h want 1/%h", ov[2], od[2], m_data[2]);
    end
    repeat (5) tick();
    checks++;
    if (oc[2] !== (CNT_EN ? 32'd5 : 32'd0)) begin
      failures++;
      $display("FAIL word_count_5 got %0d want %0d", oc[2], CNT_EN ? 5 : 0);
    end
  endtask

  task automatic test_back_to_back();
    rd[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sl[1] = 1'b1; sd[1] = 64'(k + 3);
      tick();
      checks++;
      if (ov[1] !== 1'b0) begin
        failures++;
        $display("FAIL b2b_seed%0d got valid=%b want 0", k, ov[1]);
      end
    end
    sl[1] = 1'b0;
    tick();
    checks++;
    if (ov[1] !== 1'b1 || od[1] !== m_data[1]) begin
      failures++;
      $display("FAIL b2b_refill got valid=%b data=%h want 1/%h", ov[1], od[1], m_data[1]);
    end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < N; i++) begin
        sl[i] = ($urandom_range(0, 19) == 0);
        sd[i] = ($urandom_range(0, 5) == 0) ? '1 : {$urandom, $urandom};
        rd[i] = ($urandom_range(0, 3) != 0);
      end
      tick();
      for (int i = 0; i < N; i++) begin
        checks++;
        if (ov[i] !== m_valid[i] || ol[i] !== m_lock[i] || (m_valid[i] && od[i] !== m_data[i]) ||
            oc[i] !== exp_cnt(i)) begin
          failures++;
          $display("FAIL random dut%0d cyc%0d valid=%b/%b lock=%b/%b data=%h/%h cnt=%0d/%0d (got/want)",
                   i, cyc, ov[i], m_valid[i], ol[i], m_lock[i], od[i], m_data[i], oc[i], exp_cnt(i));
        end
      end
    end
    for (int i = 0; i < N; i++) sl[i] = 1'b0;
  endtask

  task automatic test_reset_midstream();
    rd[2] = 1'b0;
    tick();
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    for (int i = 0; i < N; i++) begin
      checks++;
      if (ov[i] !== 1'b0 || od[i] !== 64'd0 || ol[i] !== 1'b0 || oc[i] !== 32'd0) begin
        failures++;
        $display("FAIL async_reset dut%0d valid=%b data=%h lock=%b cnt=%0d want zeros", i, ov[i], od[i], ol[i], oc[i]);
      end
    end
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    tick();
    checks++;
    if (ov[2] !== 1'b1 || od[2] !== first_w2) begin
      failures++;
      $display("FAIL restart_after_reset got valid=%b data=%h want 1/%h", ov[2], od[2], first_w2);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_period_w4();
    test_lockup();
    test_stall();
    test_seed_during_transfer();
    test_back_to_back();
    test_random();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
